sram_arb: RTL and testbench
===========================

Name: sram_arb

Overview:
- Single-port frame-SRAM arbiter for the MEMC datapath.
- Shares one SRAM macro between three requesters: the incoming pixel write stream (buffered in a small write FIFO) and two read requesters (rd0 = reference-window fetch, rd1 = current-block fetch).
- Issues at most one SRAM access per cycle. Write drain has priority, bounded by a read-starvation limit; the two reads are served round-robin.
- Returns read data with a tagged valid after a fixed SRAM latency.

Parameters:
ADDR_W, 12, SRAM address width (6-bit row + 6-bit column)
DATA_W, 8, pixel width
WF_DEPTH, 4, write FIFO depth (power of 2, >=2)
STARVE_MAX, 3, max consecutive write grants while a read is pending
RD_LAT, 1, SRAM read latency in cycles (1 or 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wr_valid  in  1  write push request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write pixel
wr_ready  out  1  FIFO can accept a push (!full)
wf_afull  out  1  FIFO count >= WF_DEPTH-1 (upstream raises busy)
rd0_req  in  1  read request, reference window
rd0_addr  in  ADDR_W  rd0 address
rd0_gnt  out  1  rd0 accepted this cycle
rd1_req  in  1  read request, current block
rd1_addr  in  ADDR_W  rd1 address
rd1_gnt  out  1  rd1 accepted this cycle
rd0_rvalid  out  1  rdata belongs to rd0
rd1_rvalid  out  1  rdata belongs to rd1
rdata  out  DATA_W  read data (sram_q passthrough)
sram_ce  out  1  SRAM access enable
sram_we  out  1  1 = write, 0 = read
sram_a  out  ADDR_W  SRAM address
sram_d  out  DATA_W  SRAM write data
sram_q  in  DATA_W  SRAM read data, valid RD_LAT cycles after a read access

Behaviour:
Reset (asynchronous, while rst is high):
- FIFO emptied, starve counter = 0, RR pointer = rd0, rvalid pipeline cleared.
- Outputs: wr_ready=0, all gnt=0, sram_ce=0, sram_we=0, rvalid=0, wf_afull=0.
- First cycle after rst deasserts: wr_ready=1.

Write FIFO:
- Push when wr_valid && wr_ready.
- wr_ready = !full. No push when full, even if a pop occurs the same cycle.
- Pop only on a write grant.
- Push into an empty FIFO is visible to the arbiter the next cycle (1-cycle minimum write latency).

Arbitration (combinational per cycle from FIFO state, req, counter and pointer):
- rd_pend = rd0_req | rd1_req.
- Write grant when FIFO non-empty and (!rd_pend or starve_cnt < STARVE_MAX).
- Otherwise, if rd_pend: read grant.
  - Both requesting: serve the RR pointer's requester.
  - One requesting: serve that one.
- Otherwise: idle, sram_ce=0.

Sequential updates:
- Starve counter: +1 on a write grant while rd_pend; reset to 0 on any read grant or when !rd_pend; saturates at STARVE_MAX.
- RR pointer: after a read grant, points to the other read requester.

Request handshake:
- Requester holds req and addr stable until gnt; a transaction completes in the gnt cycle.
- Deasserting req without gnt is legal (request withdrawn).
- gnt asserts only when the matching req is high.

SRAM drive (combinational from the grant):
- sram_ce = any grant.
- sram_we = write grant.
- sram_a = granted address.
- sram_d = FIFO head data.

Read return:
- Shift register of depth RD_LAT carries a 2-bit tag {rd1, rd0}.
- rdN_rvalid asserts exactly RD_LAT cycles after rdN_gnt, one cycle per grant.
- Back-to-back reads pipeline with no bubbles.

Scope exclusions:
- No read-after-write forwarding. The frame sequencer guarantees reads target the bank not being written; verification must respect this.

Boundary cases:
- Simultaneous push and pop on a non-full FIFO: count unchanged.
- rd_pend high with the FIFO empty: read is served regardless of the counter.
- Counter reaching STARVE_MAX with the FIFO full: read still wins one cycle. wr_ready stays 0, so upstream must honour wf_afull/busy.
- rst asserted mid-operation: queued writes are dropped and in-flight rvalids are suppressed.

Decomposition:
- Shared package memc_pkg:
  - constants ADDR_W=12, DATA_W=8
  - requester id enum {REQ_NONE, REQ_WR, REQ_RD0, REQ_RD1}
  - RD_LAT default
- Sub-module arb_wfifo: parameterised DATA_W+ADDR_W wide synchronous FIFO with push/pop, full, empty and count outputs.
- Arbitration, counter, pointer and rvalid pipeline stay in sram_arb.

Test Plan:
- Reset, then push 4 writes (addr 0x000..0x003, data 0x10..0x13) with no reads -> writes appear on sram_a/sram_d in order, one per cycle, starting 1 cycle after the first push; wr_ready drops after the 4th push if no pop occurred.
- rd0_req and rd1_req held high continuously, FIFO empty -> grants alternate rd0, rd1, rd0, ...; each rdN_rvalid follows its grant by RD_LAT with rdata = sram_q.
- FIFO kept non-empty by continuous pushes, rd0_req high from cycle 0 -> 3 write grants, then 1 rd0 grant, then writes resume (STARVE_MAX=3).
- FIFO full (4 entries), wr_valid held high -> wr_ready=0, no push accepted, wf_afull=1; after one pop, wr_ready=1 the next cycle.
- rst pulsed while 3 writes are queued and an rd1 grant is in flight -> no further sram_ce; rd1_rvalid stays 0; FIFO empty after reset.
- rd0_req withdrawn before grant while a write drains -> no rd0_gnt, no rd0_rvalid, starve counter returns to 0.

Source files
------------

// File: rtl/memc_pkg.sv
// Shared MEMC datapath definitions: pixel/address widths, requester ids and SRAM latency.
package memc_pkg;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_WR,
    REQ_RD0,
    REQ_RD1
  } req_e;

endpackage

// File: rtl/sram_arb_if.sv
// Bus bundle between the frame-SRAM arbiter, its three requesters and the SRAM macro.
interface sram_arb_if;
  import memc_pkg::*;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wf_afull;

  logic              rd0_req;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd0_gnt;
  logic              rd1_req;
  logic [ADDR_W-1:0] rd1_addr;
  logic              rd1_gnt;

  logic              rd0_rvalid;
  logic              rd1_rvalid;
  logic [DATA_W-1:0] rdata;

  logic              sram_ce;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd0_req, rd0_addr, rd1_req, rd1_addr, sram_q,
    output wr_ready, wf_afull, rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid, rdata,
           sram_ce, sram_we, sram_a, sram_d
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd0_req, rd0_addr, rd1_req, rd1_addr, sram_q,
    input  wr_ready, wf_afull, rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid, rdata,
           sram_ce, sram_we, sram_a, sram_d
  );

endinterface

// File: rtl/arb_wfifo.sv
// Small power-of-two write FIFO holding {addr, data} entries waiting for an SRAM write slot.
module arb_wfifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic          pushOk, popOk;

  // A push is refused when full, even if a pop frees a slot in the same cycle.
  assign pushOk  = push_i & ~full_o;
  assign popOk   = pop_i & ~empty_o;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    if (pushOk && !popOk) begin
      count_d = count_q + CW'(1);
    end else if (!pushOk && popOk) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (pushOk) wrPtr_q <= wrPtr_q + PW'(1);
      if (popOk)  rdPtr_q <= rdPtr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/sram_arb.sv
// Single-port frame-SRAM arbiter: buffered pixel writes with bounded priority over two
// round-robin read requesters, plus a tagged read-return pipeline.
module sram_arb
  import memc_pkg::*;
#(
  parameter int WF_DEPTH   = 4,
  parameter int STARVE_MAX = 3,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  sram_arb_if.slave  bus
);

  localparam int CW = $clog2(WF_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int FW = ADDR_W + DATA_W;

  logic              fifoFull, fifoEmpty;
  logic [CW-1:0]     fifoCount;
  logic [FW-1:0]     fifoHead;
  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;
  logic              wrReady;
  logic              rdPend;
  req_e              grant;

  logic [SW-1:0]     starve_q, starve_d;
  logic              rrPtr_q, rrPtr_d;
  logic [1:0]        tag_q [RD_LAT];

  assign wrReady  = ~fifoFull & ~rst;
  assign rdPend   = bus.rd0_req | bus.rd1_req;
  assign headAddr = fifoHead[FW-1:DATA_W];
  assign headData = fifoHead[DATA_W-1:0];

  arb_wfifo #(
    .W     (FW),
    .DEPTH (WF_DEPTH)
  ) u_wfifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.wr_valid & wrReady),
    .data_i  ({bus.wr_addr, bus.wr_data}),
    .pop_i   (grant == REQ_WR),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Writes win until reads have waited STARVE_MAX grants; rrPtr_q=1 means rd1 goes next.
  always_comb begin
    grant = REQ_NONE;
    if (!rst) begin
      if (!fifoEmpty && (!rdPend || starve_q < SW'(STARVE_MAX))) begin
        grant = REQ_WR;
      end else if (bus.rd0_req && bus.rd1_req) begin
        grant = rrPtr_q ? REQ_RD1 : REQ_RD0;
      end else if (bus.rd0_req) begin
        grant = REQ_RD0;
      end else if (bus.rd1_req) begin
        grant = REQ_RD1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    rrPtr_d  = rrPtr_q;
    if (grant == REQ_RD0 || grant == REQ_RD1 || !rdPend) begin
      starve_d = '0;
    end else if (grant == REQ_WR && starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
    if (grant == REQ_RD0) rrPtr_d = 1'b1;
    if (grant == REQ_RD1) rrPtr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      rrPtr_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= 2'b00;
    end else begin
      starve_q <= starve_d;
      rrPtr_q  <= rrPtr_d;
      tag_q[0] <= {grant == REQ_RD1, grant == REQ_RD0};
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    bus.sram_a = '0;
    case (grant)
      REQ_WR:  bus.sram_a = headAddr;
      REQ_RD0: bus.sram_a = bus.rd0_addr;
      REQ_RD1: bus.sram_a = bus.rd1_addr;
      default: bus.sram_a = '0;
    endcase
  end

  assign bus.sram_ce    = (grant != REQ_NONE);
  assign bus.sram_we    = (grant == REQ_WR);
  assign bus.sram_d     = headData;
  assign bus.rd0_gnt    = (grant == REQ_RD0);
  assign bus.rd1_gnt    = (grant == REQ_RD1);
  assign bus.wr_ready   = wrReady;
  assign bus.wf_afull   = ~rst & (fifoCount >= CW'(WF_DEPTH - 1));
  assign bus.rd0_rvalid = tag_q[RD_LAT-1][0];
  assign bus.rd1_rvalid = tag_q[RD_LAT-1][1];
  assign bus.rdata      = bus.sram_q;

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sram_arb;

  localparam int WF_DEPTH   = 4;
  localparam int STARVE_MAX = 3;
  localparam int RD_LAT     = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nVectors = 0;
  int   nMiscompares = 0;

  sram_arb_if bus();

  sram_arb #(
    .WF_DEPTH   (WF_DEPTH),
    .STARVE_MAX (STARVE_MAX),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro with a one-cycle registered read.
  logic [7:0] mem [4096];
  logic [7:0] sramQ;
  assign bus.sram_q = sramQ;

  always @(posedge clk) begin
    if (bus.sram_ce) begin
      if (bus.sram_we) mem[bus.sram_a] <= bus.sram_d;
      else             sramQ <= mem[bus.sram_a];
    end
  end

  function automatic logic [7:0] initVal(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending writes, pending read returns and arbitration history.
  typedef struct {
    int         due;
    bit         id;
    logic [7:0] data;
  } ret_t;

  logic [19:0] wq [$];
  ret_t        retQ [$];
  logic [7:0]  shadow [4096];
  int          starve = 0;
  bit          rrNext = 0;
  int          mGrant = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      wq.delete();
      retQ.delete();
      starve = 0;
      rrNext = 0;
      mGrant = 0;
      checkOutput("rstWrReady", bus.wr_ready, 0);
      checkOutput("rstAfull", bus.wf_afull, 0);
      checkOutput("rstCe", bus.sram_ce, 0);
      checkOutput("rstWe", bus.sram_we, 0);
      checkOutput("rstGnt", {bus.rd1_gnt, bus.rd0_gnt}, 0);
      checkOutput("rstRvalid", {bus.rd1_rvalid, bus.rd0_rvalid}, 0);
    end else begin
      bit         rdPend, full, rv0, rv1;
      logic [7:0] rdExp;
      rdPend = bus.rd0_req | bus.rd1_req;
      full   = (wq.size() == WF_DEPTH);
      if (wq.size() > 0 && (!rdPend || starve < STARVE_MAX)) mGrant = 1;
      else if (bus.rd0_req && bus.rd1_req) mGrant = rrNext ? 3 : 2;
      else if (bus.rd0_req) mGrant = 2;
      else if (bus.rd1_req) mGrant = 3;
      else mGrant = 0;

      rv0 = 0; rv1 = 0; rdExp = '0;
      if (retQ.size() > 0 && retQ[0].due == cyc) begin
        rv0   = (retQ[0].id == 0);
        rv1   = (retQ[0].id == 1);
        rdExp = retQ[0].data;
      end

      checkOutput("wrReady", bus.wr_ready, !full);
      checkOutput("afull", bus.wf_afull, wq.size() >= WF_DEPTH - 1);
      checkOutput("ce", bus.sram_ce, mGrant != 0);
      checkOutput("we", bus.sram_we, mGrant == 1);
      checkOutput("rd0Gnt", bus.rd0_gnt, mGrant == 2);
      checkOutput("rd1Gnt", bus.rd1_gnt, mGrant == 3);
      checkOutput("rd0Rvalid", bus.rd0_rvalid, rv0);
      checkOutput("rd1Rvalid", bus.rd1_rvalid, rv1);
      if (rv0 || rv1) checkOutput("rdata", bus.rdata, rdExp);
      if (mGrant == 1) begin
        checkOutput("wrAddr", bus.sram_a, wq[0][19:8]);
        checkOutput("wrData", bus.sram_d, wq[0][7:0]);
      end
      if (mGrant == 2) checkOutput("rd0Addr", bus.sram_a, bus.rd0_addr);
      if (mGrant == 3) checkOutput("rd1Addr", bus.sram_a, bus.rd1_addr);

      if (mGrant == 1) begin
        shadow[wq[0][19:8]] = wq[0][7:0];
        void'(wq.pop_front());
      end
      if (mGrant == 2) retQ.push_back('{cyc + RD_LAT, 1'b0, shadow[bus.rd0_addr]});
      if (mGrant == 3) retQ.push_back('{cyc + RD_LAT, 1'b1, shadow[bus.rd1_addr]});
      if (bus.wr_valid && !full) wq.push_back({bus.wr_addr, bus.wr_data});
      if (mGrant >= 2 || !rdPend) starve = 0;
      else if (mGrant == 1 && starve < STARVE_MAX) starve++;
      if (mGrant == 2) rrNext = 1;
      if (mGrant == 3) rrNext = 0;
      while (retQ.size() > 0 && retQ[0].due <= cyc) void'(retQ.pop_front());
    end
    cyc++;
  end

  // Drives one cycle of inputs after the rising edge and returns just after the falling edge.
  task automatic applyStimulus(input bit wv, input logic [11:0] wa, input logic [7:0] wd,
                               input bit r0, input logic [11:0] a0,
                               input bit r1, input logic [11:0] a1);
    @(posedge clk);
    #1;
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd0_req  = r0;
    bus.rd0_addr = a0;
    bus.rd1_req  = r1;
    bus.rd1_addr = a1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, 0, '0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = initVal(i);
      shadow[i] = initVal(i);
    end
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd0_req = 0; bus.rd0_addr = '0; bus.rd1_req = 0; bus.rd1_addr = '0;
    sramQ = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("wrReadyAfterRst", bus.wr_ready, 1);

    $display("[TB] write drain, no reads");
    applyStimulus(1, 12'h000, 8'h10, 0, '0, 0, '0);
    checkOutput("t1IdleFirst", bus.sram_ce, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(i < 4, 12'(i), 8'(8'h10 + i), 0, '0, 0, '0);
      checkOutput("t1We", bus.sram_we, 1);
      checkOutput("t1Addr", bus.sram_a, 12'(i - 1));
      checkOutput("t1Data", bus.sram_d, 8'h10 + 8'(i - 1));
    end
    idle(1);
    checkOutput("t1Drained", bus.sram_ce, 0);

    $display("[TB] round-robin reads");
    applyStimulus(0, '0, '0, 1, 12'h800, 1, 12'h840);
    checkOutput("t2Gnt0", {bus.rd1_gnt, bus.rd0_gnt}, 2'b01);
    applyStimulus(0, '0, '0, 1, 12'h800, 1, 12'h840);
    checkOutput("t2Gnt1", {bus.rd1_gnt, bus.rd0_gnt}, 2'b10);
    checkOutput("t2Rv0", {bus.rd1_rvalid, bus.rd0_rvalid}, 2'b01);
    checkOutput("t2Rdata0", bus.rdata, 8'h5A);
    applyStimulus(0, '0, '0, 1, 12'h800, 1, 12'h840);
    checkOutput("t2Gnt2", {bus.rd1_gnt, bus.rd0_gnt}, 2'b01);
    checkOutput("t2Rv1", {bus.rd1_rvalid, bus.rd0_rvalid}, 2'b10);
    checkOutput("t2Rdata1", bus.rdata, 8'h1A);
    idle(2);

    $display("[TB] write priority bounded by starvation limit");
    applyStimulus(1, 12'h010, 8'h20, 0, '0, 0, '0);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(i <= 5, 12'(12'h010 + i), 8'(8'h20 + i), (i <= 4), 12'h801, 0, '0);
      if (i <= 3) checkOutput("t3Write", bus.sram_we, 1);
      if (i == 4) checkOutput("t3ReadWins", bus.rd0_gnt, 1);
      if (i == 5) begin
        checkOutput("t3Resume", bus.sram_a, 12'h013);
        checkOutput("t3Rdata", bus.rdata, 8'h5B);
      end
    end
    idle(3);

    $display("[TB] FIFO full with reads pending");
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1, 12'(12'h020 + i), 8'(8'h40 + i), 1, 12'h900, 1, 12'h940);
      if (bus.wr_ready === 1'b0) found = 1;
    end
    checkOutput("t4FullSeen", found, 1);
    checkOutput("t4Afull", bus.wf_afull, 1);
    applyStimulus(1, 12'h0FF, 8'hEE, 0, '0, 0, '0);
    checkOutput("t4ReadyAfterPop", bus.wr_ready, 1);
    idle(6);

    $display("[TB] reset mid-operation");
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1, 12'(12'h030 + i), 8'(8'h50 + i), 0, '0, 1, 12'h980);
      if (mGrant == 3 && wq.size() >= 3) found = 1;
    end
    checkOutput("t5Setup", found, 1);
    rst = 1'b1;
    #1;
    checkOutput("t5CeInRst", bus.sram_ce, 0);
    bus.wr_valid = 0; bus.rd1_req = 0;
    @(negedge clk); #1;
    checkOutput("t5NoRvalid", bus.rd1_rvalid, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("t5CeAfter", bus.sram_ce, 0);
    checkOutput("t5ReadyAfter", bus.wr_ready, 1);
    checkOutput("t5AfullAfter", bus.wf_afull, 0);
    checkOutput("t5RvalidAfter", bus.rd1_rvalid, 0);
    idle(1);
    checkOutput("t5StillIdle", bus.sram_ce, 0);

    $display("[TB] withdrawn read");
    applyStimulus(1, 12'h040, 8'h60, 0, '0, 0, '0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(i <= 7, 12'(12'h040 + i), 8'(8'h60 + i), (i != 3 && i <= 7), 12'hA00, 0, '0);
      if (i <= 6) checkOutput("t6NoGnt", bus.rd0_gnt, 0);
      if (i == 4) checkOutput("t6NoRvalid", bus.rd0_rvalid, 0);
      if (i == 7) checkOutput("t6LateGnt", bus.rd0_gnt, 1);
      if (i == 8) begin
        checkOutput("t6Rvalid", bus.rd0_rvalid, 1);
        checkOutput("t6Rdata", bus.rdata, 8'h5A);
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
